// File: rtl/term_cfg_repeater.sv
// Configuration-path repeater for fabric-edge terminal tiles: pipelines FrameData and
// FrameStrobe to the next tile and keeps statistics on strobe activity.
module term_cfg_repeater #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int PipeStages      = 1,
  parameter int StrobeGuard     = 0,
  parameter int CountWidth      = 16
) (
  input  logic                               UserCLK,
  input  logic                               Reset,
  output logic                               UserCLKo,
  input  logic [FrameBitsPerRow-1:0]         FrameData,
  input  logic [MaxFramesPerCol-1:0]         FrameStrobe,
  output logic [FrameBitsPerRow-1:0]         FrameData_O,
  output logic [MaxFramesPerCol-1:0]         FrameStrobe_O,
  input  logic                               ClearStats,
  output logic [CountWidth-1:0]              StrobeEvents,
  output logic [$clog2(MaxFramesPerCol)-1:0] LastStrobeIdx,
  output logic                               MultiStrobeErr
);

  localparam int IdxW  = $clog2(MaxFramesPerCol);
  localparam int PW    = FrameBitsPerRow + MaxFramesPerCol;
  localparam bit Guard = (StrobeGuard != 0);

  logic                       any;
  logic                       multi;
  logic                       any_q;
  logic                       strobe_event;
  logic [MaxFramesPerCol-1:0] gated;
  logic [IdxW-1:0]            low_idx;

  // The clock leaves the tile on a plain wire so the buffer cell can be placed by the tool.
  assign UserCLKo = UserCLK;

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign any          = |FrameStrobe;
  assign multi        = |(FrameStrobe & (FrameStrobe - MaxFramesPerCol'(1)));
  assign gated        = (Guard && multi) ? '0 : FrameStrobe;
  assign strobe_event = any && !any_q;

  always_comb begin
    low_idx = '0;
    for (int i = MaxFramesPerCol - 1; i >= 0; i--) begin
      if (FrameStrobe[i]) low_idx = IdxW'(i);
    end
  end

  if (PipeStages == 0) begin : g_comb
    assign FrameData_O   = FrameData;
    assign FrameStrobe_O = gated;
  end else begin : g_pipe
    logic [PW-1:0] pipe [PipeStages];

    always_ff @(posedge UserCLK) begin
      if (Reset) begin
        for (int i = 0; i < PipeStages; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= {FrameData, gated};
        for (int i = 1; i < PipeStages; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign {FrameData_O, FrameStrobe_O} = pipe[PipeStages-1];
  end

  // ClearStats wins over a simultaneous event, but edge tracking keeps running through it.
  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      any_q          <= 1'b0;
      StrobeEvents   <= '0;
      LastStrobeIdx  <= '0;
      MultiStrobeErr <= 1'b0;
    end else begin
      any_q <= any;
      if (ClearStats) begin
        StrobeEvents   <= '0;
        LastStrobeIdx  <= '0;
        MultiStrobeErr <= 1'b0;
      end else begin
        if (strobe_event) begin
          if (StrobeEvents != '1) StrobeEvents <= StrobeEvents + CountWidth'(1);
          LastStrobeIdx <= low_idx;
        end
        if (multi) MultiStrobeErr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_term_cfg_repeater.sv
// Self-checking bench: four repeater configurations share one stimulus stream and are
// compared against a cycle-history reference model, a constant vector table and hand sequences.
module tb_term_cfg_repeater;

  localparam int DW = 32;
  localparam int SW = 20;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic [DW-1:0] data = '0;
  logic [SW-1:0] strobe = '0;

  always #5 clk = ~clk;

  logic a_clko, b_clko, c_clko, d_clko;
  logic [DW-1:0] a_data, b_data, c_data, d_data;
  logic [SW-1:0] a_strb, b_strb, c_strb, d_strb;
  logic [15:0]   a_ev, c_ev, d_ev;
  logic [3:0]    b_ev;
  logic [IW-1:0] a_idx, b_idx, c_idx, d_idx;
  logic          a_err, b_err, c_err, d_err;

  term_cfg_repeater #(.FrameBitsPerRow(DW), .MaxFramesPerCol(SW), .PipeStages(2),
                      .StrobeGuard(0), .CountWidth(16)) u_a (
    .UserCLK(clk), .Reset(rst), .UserCLKo(a_clko), .FrameData(data), .FrameStrobe(strobe),
    .FrameData_O(a_data), .FrameStrobe_O(a_strb), .ClearStats(clr),
    .StrobeEvents(a_ev), .LastStrobeIdx(a_idx), .MultiStrobeErr(a_err));

  term_cfg_repeater #(.FrameBitsPerRow(DW), .MaxFramesPerCol(SW), .PipeStages(3),
                      .StrobeGuard(1), .CountWidth(4)) u_b (
    .UserCLK(clk), .Reset(rst), .UserCLKo(b_clko), .FrameData(data), .FrameStrobe(strobe),
    .FrameData_O(b_data), .FrameStrobe_O(b_strb), .ClearStats(clr),
    .StrobeEvents(b_ev), .LastStrobeIdx(b_idx), .MultiStrobeErr(b_err));

  term_cfg_repeater #(.FrameBitsPerRow(DW), .MaxFramesPerCol(SW), .PipeStages(0),
                      .StrobeGuard(1), .CountWidth(16)) u_c (
    .UserCLK(clk), .Reset(rst), .UserCLKo(c_clko), .FrameData(data), .FrameStrobe(strobe),
    .FrameData_O(c_data), .FrameStrobe_O(c_strb), .ClearStats(clr),
    .StrobeEvents(c_ev), .LastStrobeIdx(c_idx), .MultiStrobeErr(c_err));

  term_cfg_repeater #(.FrameBitsPerRow(DW), .MaxFramesPerCol(SW), .PipeStages(1),
                      .StrobeGuard(0), .CountWidth(16)) u_d (
    .UserCLK(clk), .Reset(rst), .UserCLKo(d_clko), .FrameData(data), .FrameStrobe(strobe),
    .FrameData_O(d_data), .FrameStrobe_O(d_strb), .ClearStats(clr),
    .StrobeEvents(d_ev), .LastStrobeIdx(d_idx), .MultiStrobeErr(d_err));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: inputs accepted since the last reset, plus abstract statistics.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } samp_t;

  samp_t hist[$];
  int    m_events   = 0;
  logic  m_prev_any = 1'b0;
  int    m_idx      = 0;
  logic  m_err      = 1'b0;

  function automatic int cfg_dly(int i);
    case (i)
      0: return 2;
      1: return 3;
      2: return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int cfg_guard(int i);
    return (i == 1 || i == 2) ? 1 : 0;
  endfunction

  function automatic int cfg_cw(int i);
    return (i == 1) ? 4 : 16;
  endfunction

  function automatic logic [SW-1:0] guarded(logic [SW-1:0] s, int g);
    return (g != 0 && $countones(s) >= 2) ? '0 : s;
  endfunction

  function automatic int lowest_bit(logic [SW-1:0] s);
    for (int i = 0; i < SW; i++) if (s[i]) return i;
    return 0;
  endfunction

  task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic any;
    if (rst) begin
      hist.delete();
      m_events   = 0;
      m_prev_any = 1'b0;
      m_idx      = 0;
      m_err      = 1'b0;
    end else begin
      any = (strobe != '0);
      if (clr) begin
        m_events = 0;
        m_idx    = 0;
        m_err    = 1'b0;
      end else begin
        if (any && !m_prev_any) begin
          m_events++;
          m_idx = lowest_bit(strobe);
        end
        if ($countones(strobe) >= 2) m_err = 1'b1;
      end
      m_prev_any = any;
      hist.push_back('{d: data, s: strobe});
      if (hist.size() > 8) void'(hist.pop_front());
    end
  endtask

  task automatic check_inst(string tag, int i, logic [DW-1:0] ad, logic [SW-1:0] as,
                            logic [15:0] ev, logic [IW-1:0] idx, logic err);
    int            dly;
    int            sat;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    dly = cfg_dly(i);
    sat = (1 << cfg_cw(i)) - 1;
    if (dly == 0) begin
      ed = data;
      es = guarded(strobe, cfg_guard(i));
    end else if (hist.size() >= dly) begin
      ed = hist[hist.size() - dly].d;
      es = guarded(hist[hist.size() - dly].s, cfg_guard(i));
    end else begin
      ed = '0;
      es = '0;
    end
    compare({tag, ".data_o"},   ad, ed);
    compare({tag, ".strobe_o"}, as, es);
    compare({tag, ".events"},   ev, (m_events < sat) ? m_events : sat);
    compare({tag, ".last_idx"}, idx, m_idx);
    compare({tag, ".multi_err"}, err, m_err);
  endtask

  task automatic check_output();
    check_inst("u_a", 0, a_data, a_strb, a_ev, a_idx, a_err);
    check_inst("u_b", 1, b_data, b_strb, {12'h0, b_ev}, b_idx, b_err);
    check_inst("u_c", 2, c_data, c_strb, c_ev, c_idx, c_err);
    check_inst("u_d", 3, d_data, d_strb, d_ev, d_idx, d_err);
    compare("clk_through", {a_clko, b_clko, c_clko, d_clko}, {4{clk}});
  endtask

  task automatic apply_stimulus(logic r, logic c, logic [DW-1:0] d, logic [SW-1:0] s);
    @(negedge clk);
    rst    = r;
    clr    = c;
    data   = d;
    strobe = s;
    @(posedge clk);
    model_step();
    #1;
    check_output();
  endtask

  // Hand-derived expectations for u_a (two stages, no guard, 16-bit counter).
  typedef struct {
    logic          r;
    logic          c;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [15:0]   ev;
    logic [IW-1:0] idx;
    logic          err;
    logic [DW-1:0] dout;
    logic [SW-1:0] sout;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [SW-1:0] rs;
    int            kind;

    tbl[0]  = '{1'b1, 1'b0, 32'h0,         20'h0,  16'd0, 5'd0, 1'b0, 32'h0,         20'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,         20'h80, 16'd1, 5'd7, 1'b0, 32'h0,         20'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,         20'h80, 16'd1, 5'd7, 1'b0, 32'h0,         20'h80};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,         20'h80, 16'd1, 5'd7, 1'b0, 32'h0,         20'h80};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,         20'h80, 16'd1, 5'd7, 1'b0, 32'h0,         20'h80};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,         20'h80, 16'd1, 5'd7, 1'b0, 32'h0,         20'h80};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,         20'h0,  16'd1, 5'd7, 1'b0, 32'h0,         20'h80};
    tbl[7]  = '{1'b0, 1'b0, 32'hDEAD_BEEF, 20'h80, 16'd2, 5'd7, 1'b0, 32'h0,         20'h0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,         20'h0,  16'd2, 5'd7, 1'b0, 32'hDEAD_BEEF, 20'h80};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,         20'h11, 16'd3, 5'd0, 1'b1, 32'h0,         20'h0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,         20'h0,  16'd3, 5'd0, 1'b1, 32'h0,         20'h11};
    tbl[11] = '{1'b0, 1'b1, 32'h0,         20'h8,  16'd0, 5'd0, 1'b0, 32'h0,         20'h0};
    tbl[12] = '{1'b0, 1'b0, 32'h0,         20'h0,  16'd0, 5'd0, 1'b0, 32'h0,         20'h8};
    tbl[13] = '{1'b0, 1'b0, 32'hA5A5_0001, 20'h4,  16'd1, 5'd2, 1'b0, 32'h0,         20'h0};
    tbl[14] = '{1'b0, 1'b0, 32'h0,         20'h0,  16'd1, 5'd2, 1'b0, 32'hA5A5_0001, 20'h4};
    tbl[15] = '{1'b0, 1'b0, 32'h0,         20'h0,  16'd1, 5'd2, 1'b0, 32'h0,         20'h0};

    for (int k = 0; k < 16; k++) begin
      apply_stimulus(tbl[k].r, tbl[k].c, tbl[k].d, tbl[k].s);
      compare($sformatf("tbl%0d.events", k),   a_ev,   tbl[k].ev);
      compare($sformatf("tbl%0d.last_idx", k), a_idx,  tbl[k].idx);
      compare($sformatf("tbl%0d.multi_err", k), a_err, tbl[k].err);
      compare($sformatf("tbl%0d.data_o", k),   a_data, tbl[k].dout);
      compare($sformatf("tbl%0d.strobe_o", k), a_strb, tbl[k].sout);
    end

    // Twenty separate events: the 4-bit counter must pin at 15 while wider ones reach 20.
    apply_stimulus(1'b1, 1'b0, '0, '0);
    for (int k = 0; k < 20; k++) begin
      apply_stimulus(1'b0, 1'b0, '0, 20'h1);
      apply_stimulus(1'b0, 1'b0, '0, 20'h0);
    end
    compare("sat.b_events", {12'h0, b_ev}, 32'd15);
    compare("sat.a_events", a_ev, 32'd20);
    compare("sat.d_events", d_ev, 32'd20);

    // Guarded vs unguarded forwarding of a two-bit strobe.
    apply_stimulus(1'b0, 1'b0, 32'h0000_00FF, 20'h11);
    compare("guard.c_strobe_o", c_strb, 32'h0);
    compare("guard.c_data_o", c_data, 32'h0000_00FF);
    compare("guard.d_strobe_o", d_strb, 32'h11);
    compare("guard.b_err", b_err, 32'h1);
    compare("guard.b_idx", b_idx, 32'h0);
    apply_stimulus(1'b0, 1'b0, '0, '0);
    apply_stimulus(1'b0, 1'b0, '0, '0);
    compare("guard.b_strobe_o", b_strb, 32'h0);
    compare("guard.b_data_o", b_data, 32'h0000_00FF);

    // A frame caught in stage 1 of u_b by reset must never emerge.
    apply_stimulus(1'b0, 1'b0, 32'h1234_5678, 20'h2);
    apply_stimulus(1'b1, 1'b0, '0, '0);
    compare("rst.b_data_o", b_data, 32'h0);
    compare("rst.b_strobe_o", b_strb, 32'h0);
    compare("rst.b_events", {12'h0, b_ev}, 32'h0);
    compare("rst.b_err", b_err, 32'h0);
    compare("rst.b_idx", b_idx, 32'h0);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b0, 1'b0, '0, '0);
      compare($sformatf("rst.flush%0d.data_o", k), b_data, 32'h0);
      compare($sformatf("rst.flush%0d.strobe_o", k), b_strb, 32'h0);
    end

    for (int k = 0; k < 500; k++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4)      rs = '0;
      else if (kind < 8) rs = SW'(1) << $urandom_range(0, SW - 1);
      else               rs = SW'($urandom);
      apply_stimulus($urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0, $urandom, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
